// File: rtl/cpu_bus_sched_pkg.sv
// Shared Lynx bus definitions: RAM ownership states and default scheduler timing.
package lynx_bus_pkg;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_VID = 1'b1
  } owner_e;

  localparam int DEF_DIV     = 4;
  localparam int DEF_VID_CYC = 2;
  localparam int DEF_MIN_CPU = 1;
  localparam int RAM_AW      = 16;

endpackage

// File: rtl/cpu_bus_sched_if.sv
// CPU, video and RAM-side signals of the bus scheduler, bundled as one interface.
interface cpu_bus_sched_if;
  import lynx_bus_pkg::*;

  logic              cep;
  logic              cen;
  logic              cpu_mreq_n;
  logic              cpu_wr_n;
  logic [RAM_AW-1:0] cpu_a;
  logic              vid_req;
  logic [RAM_AW-1:0] vid_addr;
  logic              vid_ack;
  logic [RAM_AW-1:0] ram_a;
  logic              ram_we;
  logic              stall;

  modport slave (
    input  cpu_mreq_n, cpu_wr_n, cpu_a, vid_req, vid_addr,
    output cep, cen, vid_ack, ram_a, ram_we, stall
  );

  modport master (
    output cpu_mreq_n, cpu_wr_n, cpu_a, vid_req, vid_addr,
    input  cep, cen, vid_ack, ram_a, ram_we, stall
  );

endinterface

// File: rtl/cpu_bus_sched_ce_divider.sv
// Turns the T-state counter into registered cep/cen pulses and an end-of-T-state strobe;
// everything is silenced while the divider is frozen for a video fetch.
module ce_divider #(
  parameter int DIV = 4,
  parameter int CW  = $clog2(DIV)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [CW-1:0] cnt,
  input  logic [CW-1:0] cnt_next,
  input  logic          freeze,
  input  logic          freeze_next,
  output logic          cep,
  output logic          cen,
  output logic          t_end
);

  assign t_end = ~freeze & (cnt == CW'(DIV - 1));

  // cep marks a fresh T-state: either a wrap to 0 or the resume after a freeze.
  always_ff @(posedge clock) begin
    if (reset) begin
      cep <= 1'b0;
      cen <= 1'b0;
    end else begin
      cep <= ~freeze_next & (cnt_next == '0) & (freeze | (cnt != '0));
      cen <= ~freeze_next & (cnt_next == CW'(DIV / 2));
    end
  end

endmodule

// File: rtl/cpu_bus_sched.sv
// Shares the system RAM between the Z80 and video fetch by stretching a CPU T-state
// while video owns the bus; also generates the T80pa clock enables.
module cpu_bus_sched
  import lynx_bus_pkg::*;
#(
  parameter int DIV     = DEF_DIV,
  parameter int VID_CYC = DEF_VID_CYC,
  parameter int MIN_CPU = DEF_MIN_CPU
) (
  input  logic            clock,
  input  logic            reset,
  cpu_bus_sched_if.slave  bus
);

  localparam int CW = $clog2(DIV);
  localparam int VW = (VID_CYC > 1) ? $clog2(VID_CYC) : 1;
  localparam int GW = $clog2(MIN_CPU + 1);

  owner_e            state;
  owner_e            state_next;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_next;
  logic [VW-1:0]     vcnt;
  logic [VW-1:0]     vcnt_next;
  logic [GW-1:0]     gap;
  logic              pending;
  logic [RAM_AW-1:0] vaddr;
  logic              t_end;
  logic              grant;
  logic              vid_done;

  ce_divider #(
    .DIV (DIV),
    .CW  (CW)
  ) u_ce_divider (
    .clock       (clock),
    .reset       (reset),
    .cnt         (cnt),
    .cnt_next    (cnt_next),
    .freeze      (state == OWN_VID),
    .freeze_next (state_next == OWN_VID),
    .cep         (bus.cep),
    .cen         (bus.cen),
    .t_end       (t_end)
  );

  // gap is decremented on this same boundary, so a value of 1 already counts as expired.
  always_comb begin
    grant      = (state == OWN_CPU) & t_end & pending & (gap <= GW'(1));
    vid_done   = (state == OWN_VID) & (vcnt == VW'(VID_CYC - 1));
    state_next = state;
    cnt_next   = cnt;
    vcnt_next  = vcnt;
    if (state == OWN_CPU) begin
      cnt_next = t_end ? '0 : cnt + 1'b1;
      if (grant) begin
        state_next = OWN_VID;
        vcnt_next  = '0;
      end
    end else begin
      vcnt_next = vcnt + 1'b1;
      if (vid_done) begin
        state_next = OWN_CPU;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= OWN_CPU;
      cnt         <= '0;
      vcnt        <= '0;
      gap         <= '0;
      pending     <= 1'b0;
      vaddr       <= '0;
      bus.vid_ack <= 1'b0;
      bus.stall   <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      vcnt    <= vcnt_next;
      pending <= grant ? bus.vid_req : (pending | bus.vid_req);
      if (grant) begin
        vaddr <= bus.vid_addr;
      end
      if (vid_done) begin
        gap <= GW'(MIN_CPU);
      end else if (t_end && (gap != '0)) begin
        gap <= gap - 1'b1;
      end
      bus.stall   <= (state_next == OWN_VID);
      bus.vid_ack <= (state_next == OWN_VID) & (vcnt_next == VW'(VID_CYC - 1));
    end
  end

  // A frozen CPU keeps its write pending; it lands once the divider resumes.
  assign bus.ram_a  = (state == OWN_VID) ? vaddr : bus.cpu_a;
  assign bus.ram_we = (state == OWN_CPU) & ~reset & ~bus.cpu_mreq_n & ~bus.cpu_wr_n;

endmodule

// File: tb/tb_cpu_bus_sched.sv
// Self-checking bench for cpu_bus_sched: fixed-timeline expectations plus a video-ack scoreboard.
module tb_cpu_bus_sched;

  typedef struct {
    logic [15:0] addr;
    int          ack_cyc;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc;
  int   checks;
  int   errors;
  exp_t sb_q[$];

  always #5 clock = ~clock;

  cpu_bus_sched_if bus_if ();

  cpu_bus_sched #(
    .DIV     (4),
    .VID_CYC (2),
    .MIN_CPU (1)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, actual, expected, cyc);
    end
  endtask

  task automatic applyStimulus(input logic req, input logic [15:0] vaddr, input logic mreq_n,
                               input logic wr_n, input logic [15:0] a);
    bus_if.vid_req    = req;
    bus_if.vid_addr   = vaddr;
    bus_if.cpu_mreq_n = mreq_n;
    bus_if.cpu_wr_n   = wr_n;
    bus_if.cpu_a      = a;
  endtask

  task automatic advance();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic resetDut();
    reset = 1'b1;
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b1, 16'h0000);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    cyc   = 0;
    sb_q.delete();
  endtask

  task automatic monitorAck();
    exp_t e;
    if (bus_if.vid_ack === 1'b1) begin
      if (sb_q.size() == 0) begin
        checkOutput("ack_unexpected", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        checkOutput("ack_addr", 32'(bus_if.ram_a), 32'(e.addr));
        checkOutput("ack_cycle", 32'(cyc), 32'(e.ack_cyc));
      end
    end
  endtask

  task automatic drainCheck(input string tag);
    checkOutput(tag, 32'(sb_q.size()), 32'd0);
    sb_q.delete();
  endtask

  task automatic scenNoVideo();
    logic [15:0] a;
    resetDut();
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b1, 16'h0000);
    #1;
    checkOutput("rst_cep", 32'(bus_if.cep), 32'd0);
    checkOutput("rst_cen", 32'(bus_if.cen), 32'd0);
    checkOutput("rst_stall", 32'(bus_if.stall), 32'd0);
    checkOutput("rst_vid_ack", 32'(bus_if.vid_ack), 32'd0);
    checkOutput("rst_ram_we", 32'(bus_if.ram_we), 32'd0);
    for (int i = 0; i < 16; i++) begin
      a = 16'($urandom);
      applyStimulus(1'b0, 16'h0000, 1'b1, 1'b1, a);
      #1;
      monitorAck();
      checkOutput("s1_cep", 32'(bus_if.cep), 32'((cyc % 4 == 0) && (cyc != 0)));
      checkOutput("s1_cen", 32'(bus_if.cen), 32'(cyc % 4 == 2));
      checkOutput("s1_stall", 32'(bus_if.stall), 32'd0);
      checkOutput("s1_ram_a", 32'(bus_if.ram_a), 32'(a));
      advance();
    end
    drainCheck("s1_sb_empty");
  endtask

  task automatic runFetch(input bit wr);
    logic [15:0] a;
    logic        in_vid;
    int          cep_cnt;
    int          cen_cnt;
    string       p;
    p = wr ? "s4_" : "s2_";
    cep_cnt = 0;
    cen_cnt = 0;
    resetDut();
    for (int i = 0; i < 16; i++) begin
      if (cyc == 5) sb_q.push_back('{16'h4000, 9});
      a = wr ? 16'h6000 : 16'(16'h1230 + cyc);
      applyStimulus(cyc == 5, 16'h4000, ~wr, ~wr, a);
      #1;
      monitorAck();
      in_vid = (cyc == 8) || (cyc == 9);
      checkOutput({p, "stall"}, 32'(bus_if.stall), 32'(in_vid));
      checkOutput({p, "ram_a"}, 32'(bus_if.ram_a), in_vid ? 32'h4000 : 32'(a));
      checkOutput({p, "cep"}, 32'(bus_if.cep), 32'(cyc inside {4, 10, 14}));
      checkOutput({p, "cen"}, 32'(bus_if.cen), 32'(cyc inside {2, 6, 12}));
      checkOutput({p, "ram_we"}, 32'(bus_if.ram_we), 32'(wr & ~in_vid));
      if (bus_if.cep === 1'b1) cep_cnt++;
      if (bus_if.cen === 1'b1) cen_cnt++;
      advance();
    end
    checkOutput({p, "cep_total"}, 32'(cep_cnt), 32'd3);
    checkOutput({p, "cen_total"}, 32'(cen_cnt), 32'd3);
    drainCheck({p, "sb_empty"});
  endtask

  task automatic scenSaturate();
    logic exp_stall;
    logic prev_stall;
    int   windows;
    int   cep_cnt;
    int   cen_cnt;
    windows    = 0;
    cep_cnt    = 0;
    cen_cnt    = 0;
    prev_stall = 1'b0;
    resetDut();
    for (int i = 0; i < 62; i++) begin
      if ((cyc >= 3) && ((cyc - 3) % 6 == 0)) sb_q.push_back('{16'h5A5A, cyc + 2});
      applyStimulus(1'b1, 16'h5A5A, 1'b1, 1'b1, 16'(16'h0100 + cyc));
      #1;
      monitorAck();
      exp_stall = (cyc >= 4) && ((cyc - 4) % 6 < 2);
      checkOutput("s3_stall", 32'(bus_if.stall), 32'(exp_stall));
      checkOutput("s3_cep", 32'(bus_if.cep), 32'((cyc >= 6) && ((cyc - 6) % 6 == 0)));
      checkOutput("s3_cen", 32'(bus_if.cen), 32'((cyc == 2) || ((cyc >= 8) && ((cyc - 8) % 6 == 0))));
      checkOutput("s3_ram_a", 32'(bus_if.ram_a), exp_stall ? 32'h5A5A : 32'(16'h0100 + cyc));
      if ((bus_if.stall === 1'b1) && !prev_stall) begin
        if (windows > 0) begin
          checkOutput("s3_cep_between", 32'(cep_cnt), 32'd1);
          checkOutput("s3_cen_between", 32'(cen_cnt), 32'd1);
        end
        windows++;
        cep_cnt = 0;
        cen_cnt = 0;
      end else if (bus_if.stall !== 1'b1) begin
        if (bus_if.cep === 1'b1) cep_cnt++;
        if (bus_if.cen === 1'b1) cen_cnt++;
      end
      prev_stall = (bus_if.stall === 1'b1);
      advance();
    end
    checkOutput("s3_windows", 32'(windows), 32'd10);
    drainCheck("s3_sb_empty");
  endtask

  task automatic scenCollision();
    logic prev_stall;
    int   grants;
    grants     = 0;
    prev_stall = 1'b0;
    resetDut();
    for (int i = 0; i < 32; i++) begin
      if (cyc == 5) sb_q.push_back('{16'h4000, 9});
      if (cyc == 7) sb_q.push_back('{16'h4100, 15});
      applyStimulus(cyc inside {5, 7, 8}, (cyc <= 7) ? 16'h4000 : 16'h4100, 1'b1, 1'b1, 16'h2000);
      #1;
      monitorAck();
      checkOutput("s5_stall", 32'(bus_if.stall), 32'(cyc inside {8, 9, 14, 15}));
      if ((bus_if.stall === 1'b1) && !prev_stall) grants++;
      prev_stall = (bus_if.stall === 1'b1);
      advance();
    end
    checkOutput("s5_grants", 32'(grants), 32'd2);
    drainCheck("s5_sb_empty");
  endtask

  task automatic scenResetInVid();
    resetDut();
    for (int i = 0; i < 9; i++) begin
      applyStimulus(cyc == 5, 16'h4000, 1'b1, 1'b1, 16'h3000);
      #1;
      monitorAck();
      if (cyc == 8) begin
        checkOutput("s6_in_vid", 32'(bus_if.stall), 32'd1);
        reset = 1'b1;
      end
      advance();
    end
    #1;
    monitorAck();
    checkOutput("s6_rst_stall", 32'(bus_if.stall), 32'd0);
    checkOutput("s6_rst_vid_ack", 32'(bus_if.vid_ack), 32'd0);
    checkOutput("s6_rst_cep", 32'(bus_if.cep), 32'd0);
    reset = 1'b0;
    cyc   = 0;
    for (int i = 0; i < 13; i++) begin
      applyStimulus(1'b0, 16'h4000, 1'b1, 1'b1, 16'h3000);
      #1;
      monitorAck();
      checkOutput("s6_stall", 32'(bus_if.stall), 32'd0);
      checkOutput("s6_cep", 32'(bus_if.cep), 32'(cyc inside {4, 8, 12}));
      checkOutput("s6_cen", 32'(bus_if.cen), 32'(cyc inside {2, 6, 10}));
      advance();
    end
    drainCheck("s6_sb_empty");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b1, 16'h0000);
    $display("[TB] starting cpu_bus_sched bench");
    scenNoVideo();
    runFetch(1'b0);
    runFetch(1'b1);
    scenSaturate();
    scenCollision();
    scenResetInVid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
